// File: rtl/state_led_mode_selector.sv
// Front-panel LED mode selector: synchronizes and debounces a push-button and classifies short/long presses.
// It cycles or clears the LED mode and lets host register writes take priority.
module state_led_mode_selector #(
   parameter int DEBOUNCE_CYCLES   = 200000,
   parameter int LONG_PRESS_CYCLES = 20000000,
   parameter int NUM_MODES         = 6
) (
   input  logic       clk_20mhz,
   input  logic       rst,
   input  logic       btn_n_async,
   input  logic       host_wr_en,
   input  logic [7:0] host_wr_data,
   output logic [7:0] state_led_ctr,
   output logic       mode_changed,
   output logic       btn_level,
   output logic       long_press
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES) + 1;
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
   localparam logic [7:0]        MODE_LAST = 8'(NUM_MODES - 1);

   typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} press_state_t;

   press_state_t      state, state_nxt;
   logic              btn_sync_p0, btn_sync_p1;
   logic [DB_W-1:0]   db_cnt;
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;
   logic              short_ev, long_ev;
   logic [7:0]        mode_nxt;

   function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] c);
      return (&c) ? c : c + HOLD_W'(1);
   endfunction

   function automatic logic [7:0] next_mode(input logic [7:0] cur);
      return (cur >= MODE_LAST) ? 8'h00 : cur + 8'h01;
   endfunction

   // Stage p0/p1: two-flop synchronizer, inverted so 1 means pressed
   always_ff @(posedge clk_20mhz) begin
      if (rst) begin
         btn_sync_p0 <= 1'b0;
         btn_sync_p1 <= 1'b0;
      end else begin
         btn_sync_p0 <= ~btn_n_async;
         btn_sync_p1 <= btn_sync_p0;
      end
   end

   // Debounce: level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
   always_ff @(posedge clk_20mhz) begin
      if (rst) begin
         db_cnt    <= '0;
         btn_level <= 1'b0;
      end else if (btn_sync_p1 == btn_level) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
         db_cnt    <= '0;
         btn_level <= ~btn_level;
      end else begin
         db_cnt <= db_cnt + DB_W'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      short_ev  = 1'b0;
      long_ev   = 1'b0;
      case (state)
         IDLE: begin
            if (btn_level) begin
               state_nxt = PRESSED;
               hold_nxt  = '0;
            end
         end
         PRESSED: begin
            if (!btn_level) begin
               short_ev  = 1'b1;
               state_nxt = IDLE;
            end else if (hold_cnt == HOLD_LAST) begin
               long_ev   = 1'b1;
               state_nxt = LONG_HELD;
            end else begin
               hold_nxt = hold_inc(hold_cnt);
            end
         end
         LONG_HELD: begin
            hold_nxt = hold_inc(hold_cnt);
            if (!btn_level)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Host writes override any button event landing in the same cycle
   always_comb begin
      mode_nxt = state_led_ctr;
      if (host_wr_en)
         mode_nxt = host_wr_data;
      else if (long_ev)
         mode_nxt = 8'h00;
      else if (short_ev)
         mode_nxt = next_mode(state_led_ctr);
   end

   always_ff @(posedge clk_20mhz) begin
      if (rst) begin
         state         <= IDLE;
         hold_cnt      <= '0;
         state_led_ctr <= 8'h00;
         mode_changed  <= 1'b0;
         long_press    <= 1'b0;
      end else begin
         state         <= state_nxt;
         hold_cnt      <= hold_nxt;
         state_led_ctr <= mode_nxt;
         mode_changed  <= (mode_nxt != state_led_ctr);
         long_press    <= long_ev;
      end
   end

endmodule

// File: tb/tb_state_led_mode_selector.sv
// Randomized and directed bench for state_led_mode_selector against a press-duration reference model.
module tb_state_led_mode_selector;

   localparam int DEB  = 4;
   localparam int LONG = 16;
   localparam int NM   = 6;

   logic       clk_20mhz = 1'b0;
   logic       rst;
   logic       btn_n_async;
   logic       host_wr_en;
   logic [7:0] host_wr_data;
   logic [7:0] state_led_ctr;
   logic       mode_changed;
   logic       btn_level;
   logic       long_press;

   int checks = 0;
   int errors = 0;

   state_led_mode_selector #(
      .DEBOUNCE_CYCLES  (DEB),
      .LONG_PRESS_CYCLES(LONG),
      .NUM_MODES        (NM)
   ) dut (
      .clk_20mhz    (clk_20mhz),
      .rst          (rst),
      .btn_n_async  (btn_n_async),
      .host_wr_en   (host_wr_en),
      .host_wr_data (host_wr_data),
      .state_led_ctr(state_led_ctr),
      .mode_changed (mode_changed),
      .btn_level    (btn_level),
      .long_press   (long_press)
   );

   always #25 clk_20mhz = ~clk_20mhz;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: sampled-button history, run lengths and the resulting mode
   bit m_valid = 1'b0;
   bit h0, h1, m_level, samp, lvl_old, ev_s, ev_l, m_chg, m_lp;
   int m_diff, m_hi, m_mode, nm;

   always @(posedge clk_20mhz) begin
      if (rst) begin
         h0 = 0; h1 = 0; m_level = 0; m_diff = 0; m_hi = 0;
         m_mode = 0; m_chg = 0; m_lp = 0; m_valid = 1;
      end else begin
         samp = h1; h1 = h0; h0 = ~btn_n_async;
         lvl_old = m_level;
         if (samp != m_level) begin
            m_diff++;
            if (m_diff == DEB) begin
               m_level = ~m_level;
               m_diff = 0;
            end
         end else begin
            m_diff = 0;
         end
         // long press fires once the level has been seen high LONG+1 times in a row
         ev_s = 0; ev_l = 0;
         if (lvl_old) begin
            m_hi++;
            if (m_hi == LONG + 1) ev_l = 1;
            if (m_hi > LONG + 1) m_hi = LONG + 2;
         end else begin
            if (m_hi >= 1 && m_hi <= LONG) ev_s = 1;
            m_hi = 0;
         end
         nm = m_mode;
         if (host_wr_en) nm = int'(host_wr_data);
         else if (ev_l) nm = 0;
         else if (ev_s) nm = (m_mode >= NM - 1) ? 0 : m_mode + 1;
         m_chg = (nm != m_mode);
         m_lp = ev_l;
         m_mode = nm;
      end
   end

   int chg_cnt = 0, lp_cnt = 0, lvl_cnt = 0;

   always @(negedge clk_20mhz) begin
      if (m_valid) begin
         chk("ctr", 32'(state_led_ctr), 32'(m_mode));
         chk("mode_changed", 32'(mode_changed), 32'(m_chg));
         chk("long_press", 32'(long_press), 32'(m_lp));
         chk("btn_level", 32'(btn_level), 32'(m_level));
         if (mode_changed === 1'b1) chg_cnt++;
         if (long_press === 1'b1) lp_cnt++;
         if (btn_level === 1'b1) lvl_cnt++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk_20mhz);
   endtask

   task automatic press(input int hold);
      btn_n_async = 1'b0;
      tick(hold);
      btn_n_async = 1'b1;
      tick(20);
   endtask

   task automatic hwrite(input logic [7:0] v);
      host_wr_en = 1'b1;
      host_wr_data = v;
      tick(1);
      host_wr_en = 1'b0;
      tick(2);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int b_chg, b_lp, b_lvl, k;
      rst = 1'b1; btn_n_async = 1'b1; host_wr_en = 1'b0; host_wr_data = 8'h00;
      tick(3);
      chk("rst_ctr", 32'(state_led_ctr), 32'h00);
      chk("rst_chg", 32'(mode_changed), 32'h0);
      chk("rst_lp", 32'(long_press), 32'h0);
      chk("rst_lvl", 32'(btn_level), 32'h0);
      rst = 1'b0;
      tick(2);

      for (int i = 1; i <= 3; i++) begin
         b_chg = chg_cnt;
         press(8);
         chk("short_ctr", 32'(state_led_ctr), 32'(i));
         chk("short_model", 32'(m_mode), 32'(i));
         chk("short_pulses", 32'(chg_cnt - b_chg), 32'd1);
      end

      hwrite(8'h05);
      b_chg = chg_cnt;
      press(8);
      chk("wrap_ctr", 32'(state_led_ctr), 32'h00);
      chk("wrap_pulses", 32'(chg_cnt - b_chg), 32'd1);

      hwrite(8'h02);
      b_chg = chg_cnt; b_lvl = lvl_cnt;
      btn_n_async = 1'b0;
      tick(2);
      btn_n_async = 1'b1;
      tick(12);
      chk("glitch_lvl_cycles", 32'(lvl_cnt - b_lvl), 32'd0);
      chk("glitch_ctr", 32'(state_led_ctr), 32'h02);
      chk("glitch_pulses", 32'(chg_cnt - b_chg), 32'd0);

      hwrite(8'h03);
      b_chg = chg_cnt; b_lp = lp_cnt;
      press(30);
      chk("long_lp_pulses", 32'(lp_cnt - b_lp), 32'd1);
      chk("long_ctr", 32'(state_led_ctr), 32'h00);
      chk("long_model", 32'(m_mode), 32'h00);
      chk("long_chg_pulses", 32'(chg_cnt - b_chg), 32'd1);

      b_chg = chg_cnt; b_lp = lp_cnt;
      press(30);
      hwrite(8'h00);
      chk("long_at0_lp", 32'(lp_cnt - b_lp), 32'd1);
      chk("no_change_pulses", 32'(chg_cnt - b_chg), 32'd0);

      hwrite(8'h07);
      chk("host_off_ctr", 32'(state_led_ctr), 32'h07);
      press(8);
      chk("off_press_ctr", 32'(state_led_ctr), 32'h00);

      hwrite(8'h04);
      b_chg = chg_cnt;
      btn_n_async = 1'b0;
      tick(8);
      btn_n_async = 1'b1;
      k = 0;
      while (btn_level !== 1'b0 && k < 40) begin
         tick(1);
         k++;
      end
      chk("collide_wait_done", 32'(btn_level), 32'h0);
      host_wr_en = 1'b1; host_wr_data = 8'h02;
      tick(1);
      host_wr_en = 1'b0;
      tick(20);
      chk("collide_ctr", 32'(state_led_ctr), 32'h02);
      chk("collide_pulses", 32'(chg_cnt - b_chg), 32'd1);

      hwrite(8'h03);
      b_lp = lp_cnt;
      btn_n_async = 1'b0;
      k = 0;
      while (btn_level !== 1'b1 && k < 40) begin
         tick(1);
         k++;
      end
      chk("rst_press_wait_done", 32'(btn_level), 32'h1);
      tick(10);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("rst_press_ctr", 32'(state_led_ctr), 32'h00);
      chk("rst_press_lvl", 32'(btn_level), 32'h0);
      tick(12);
      btn_n_async = 1'b1;
      tick(20);
      chk("rst_press_lp", 32'(lp_cnt - b_lp), 32'd0);
      chk("rst_repress_ctr", 32'(state_led_ctr), 32'h01);

      for (int seg = 0; seg < 300; seg++) begin
         int len;
         btn_n_async = 1'($urandom_range(0, 1));
         len = int'($urandom_range(1, 40));
         for (int c = 0; c < len; c++) begin
            host_wr_en = ($urandom_range(0, 15) == 0);
            host_wr_data = 8'($urandom_range(0, 9));
            rst = ($urandom_range(0, 499) == 0);
            tick(1);
         end
      end
      rst = 1'b0; host_wr_en = 1'b0; btn_n_async = 1'b1;
      tick(30);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/state_led_mode_selector.md
STATE_LED_MODE_SELECTOR -- requirements
Module: state_led_mode_selector

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 200000, stable cycles required before a button level is accepted (10 ms at 20 MHz).
REQ-002 Parameter LONG_PRESS_CYCLES, default 20000000, debounced hold cycles that make a long press (1 s at 20 MHz).
REQ-003 Parameter NUM_MODES, default 6, number of valid LED modes (0x00..NUM_MODES-1).
REQ-004 clk_20mhz  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 btn_n_async  input  1  raw front-panel push-button, active-low, asynchronous to clk_20mhz.
REQ-007 host_wr_en  input  1  single-cycle host register write strobe.
REQ-008 host_wr_data  input  8  host value for state_led_ctr.
REQ-009 state_led_ctr  output  8  registered LED mode select, consumed by the LED controller.
REQ-010 mode_changed  output  1  one-cycle pulse when state_led_ctr takes a new value.
REQ-011 btn_level  output  1  debounced button level, 1 = pressed.
REQ-012 long_press  output  1  one-cycle pulse on long-press detection.

Function
REQ-013 btn_n_async SHALL pass through a 2-FF synchronizer and be inverted, giving btn_sync (1 = pressed).
REQ-014 Debounce counter SHALL clear whenever btn_sync equals btn_level, and increment otherwise.
REQ-015 When the counter reaches DEBOUNCE_CYCLES-1 with btn_sync != btn_level, btn_level SHALL toggle on the next edge and the counter SHALL clear.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES SHALL leave btn_level unchanged.
REQ-017 The press FSM SHALL have three states: IDLE, PRESSED and LONG_HELD.
REQ-018 IDLE: a btn_level 0->1 transition SHALL enter PRESSED and clear the hold counter.
REQ-019 PRESSED: the hold counter SHALL increment each cycle while btn_level=1.
REQ-020 PRESSED with btn_level falling before the hold counter reaches LONG_PRESS_CYCLES-1 SHALL be a short press and return to IDLE.
REQ-021 A short press SHALL set next mode = 0 if state_led_ctr >= NUM_MODES-1, else state_led_ctr+1; wrap 0x05->0x00 at default.
REQ-022 PRESSED with the hold counter at LONG_PRESS_CYCLES-1 SHALL pulse long_press, set state_led_ctr=0x00 and enter LONG_HELD.
REQ-023 LONG_HELD: the FSM SHALL return to IDLE on btn_level=0 with no mode increment on release.
REQ-024 A host write SHALL load host_wr_data unmodified, including out-of-range (off) values, one cycle after host_wr_en.
REQ-025 A host write and a button event in the same cycle: the host write SHALL win and the button event SHALL be discarded. The FSM still advances normally.
REQ-026 state_led_ctr SHALL update one cycle after the triggering event (short-press release, long-press threshold or host_wr_en).
REQ-027 mode_changed SHALL assert in the same cycle state_led_ctr shows a value different from its previous value.
REQ-028 No mode_changed pulse SHALL occur for a host write of the current value, or for a long press while already at 0x00.
REQ-029 long_press and mode_changed SHALL each be high for at most one consecutive cycle per event.
REQ-030 The hold counter SHALL saturate, never wrap, while in LONG_HELD.

Reset
REQ-031 While rst=1, on the next edge: state_led_ctr=0x00, mode_changed=0, long_press=0, btn_level=0, FSM=IDLE, synchronizer FFs=0 (released), all counters=0.
REQ-032 rst asserted mid-press SHALL abort the press with no mode change. A button still held at rst release SHALL be debounced afresh and treated as a new press.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16 for sim)
REQ-033 Reset, then 3 clean short presses (8-cycle hold each) -> state_led_ctr 0x01, 0x02, 0x03, with one mode_changed pulse each.
REQ-034 From mode 0x05, one short press -> state_led_ctr=0x00 (wrap) and mode_changed pulses once.
REQ-035 2-cycle low glitch on btn_n_async -> btn_level stays 0 and state_led_ctr is unchanged.
REQ-036 From 0x03, hold 30 cycles then release -> long_press pulses once, state_led_ctr=0x00, no increment on release.
REQ-037 Host write of 0x07, then one short press -> state_led_ctr=0x07, then 0x00. Host write of 0x02 in the same cycle as a short-press release from 0x04 -> state_led_ctr=0x02.
REQ-038 rst pulsed at hold cycle 10 of a press -> state_led_ctr=0x00, long_press never asserts, FSM=IDLE.
